serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

Bit-serial adder controller that sequences one `full_adder` instance over `WIDTH` clock cycles. It adds two latched `WIDTH`-bit operands plus a carry-in, LSB first, and keeps the running carry in a flop. It uses a start/busy/done handshake and presents registered sum and carry-out results. It sits between the lab's operand sources (switch/register inputs) and the result display, and trades latency for a single-adder datapath.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 2..32.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request an addition; sampled only in IDLE or DONE.
- `a` input `WIDTH`: operand A; latched on an accepted start.
- `b` input `WIDTH`: operand B; latched on an accepted start.
- `cin` input 1: carry-in; latched on an accepted start.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse in DONE.
- `sum` output `WIDTH`: registered result; holds its value until the next completion.
- `cout` output 1: registered final carry; holds like `sum`.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - `start`=1 latches `a` and `b` into shift registers `sa`/`sb`, loads the carry flop with `cin`, clears the bit counter, and goes to RUN.
  - `start`=0 stays in IDLE.
- **RUN:** every edge does the following:
  - Feeds `sa[0]`, `sb[0]` and `carry` to the `full_adder`.
  - Shifts the SUM bit into the MSB of the internal shift register `ps`, i.e. `ps` <= {SUM, `ps`[WIDTH-1:1]}.
  - Sets `carry` <= CO.
  - Shifts `sa` and `sb` right by 1.
  - Increments the counter.
- **RUN exit:** on the edge that processes bit `WIDTH`-1 (counter = `WIDTH`-1), the FSM goes to DONE. On that same edge, `sum` <= the final `ps` value (including the bit being shifted in) and `cout` <= CO.
- **DONE:** `done`=1, `busy`=0 for exactly one cycle.
  - `start`=1 here is accepted, with the same actions as IDLE, and the FSM goes to RUN. This allows back-to-back operations.
  - Otherwise the FSM goes to IDLE.
- **Output holding:** `sum`/`cout` change only on the RUN→DONE edge. Partial results are never visible on the outputs.
- **`start` while in RUN:** ignored. Operands and progress are unaffected.
- **Operand capture:** changes on `a`/`b`/`cin` after acceptance have no effect.
- **Arithmetic:** {`cout`, `sum`} = `a` + `b` + `cin`, modulo 2^(WIDTH+1); this is exact.
- **Counter:** $clog2(WIDTH) bits. It is never compared against `WIDTH`, only against `WIDTH`-1.
- **Reset:** overrides everything, including mid-operation.

## Timing
- **Reset values:**
  - State IDLE; `busy`=0, `done`=0, `sum`=0, `cout`=0.
  - Internal registers `sa`, `sb`, `ps`, `carry` and the counter are all 0.
- **Acceptance edge (E0):** `start` is high at edge E0 in IDLE/DONE. `busy`=1 from E0 through edge E0+`WIDTH`.
- **Completion:** `done`=1 and the valid `sum`/`cout` appear after edge E0+`WIDTH`, and `done` falls after E0+`WIDTH`+1. Latency from start to `done` is `WIDTH`+1 edges, counting E0 as edge 0.
- **Throughput:** with `start` held high, one result every `WIDTH`+1 cycles.
- **Reset mid-operation:** `rst` high at any edge means all outputs and state equal the reset values after that edge. Any `start` at the same edge is ignored.
- **Datapath depth:** the only combinational path is the `full_adder` (one level).
- **Output drive:** all outputs are driven directly by flops.

## Structure
- **Shared package/include `serial_adder_pkg`:**
  - State encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10. 2'b11 is illegal and recovers to IDLE.
  - Default `WIDTH`.
- **Sub-module:** exactly one instance of the existing `full_adder` (ports A, B, CI, SUM, CO).
- **Flops and control:** all flops and the FSM live in `serial_adder_ctrl`. No other sub-modules.

## Test plan
- **Basic add:** `WIDTH`=8, `a`=0x5A, `b`=0x3C, `cin`=0, `start` pulsed at E0 → `busy` for 8 cycles, `done` pulse after E0+8, `sum`=0x96, `cout`=0.
- **Carry ripple/wrap:** `a`=0xFF, `b`=0x01, `cin`=0 → `sum`=0x00, `cout`=1. Then `a`=0xFF, `b`=0xFF, `cin`=1 → `sum`=0xFF, `cout`=1.
- **Ignored start and operand isolation:** during RUN of 0x12+0x34, pulse `start` with `a`=0xFF and `b`=0xFF → result still `sum`=0x46, `cout`=0, `done` occurs once, and no second operation starts.
- **Reset mid-operation:** assert `rst` 4 cycles into RUN of 0x80+0x80 → next cycle `busy`=0, `done`=0, `sum`=0, `cout`=0, state IDLE. A new start of 0x01+0x02 then gives 0x03.
- **Back-to-back:** `start` held high with 0x10+0x20 then 0xF0+0x20 → `done` pulses 9 cycles apart with results 0x30/`cout`0 then 0x10/`cout`1, and `busy` low only during the DONE cycles.
- **Random regression:** 1000 random `a`/`b`/`cin` at `WIDTH`=8 and `WIDTH`=13 compared against a behavioural sum, checking `done` latency = `WIDTH`+1 every time.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder: the single combinational stage of the serial datapath.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic SUM,
  output logic CO
);

  assign SUM = A ^ B ^ CI;
  assign CO  = (A & B) | (CI & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: sequences one full_adder LSB-first over WIDTH
// cycles with a start/busy/done handshake and registered sum/cout.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, ps;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_co;
  logic             last_bit;
  logic             accept;

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign accept   = ((state == IDLE) || (state == DONE)) && start;

  full_adder u_fa (
    .A   (sa[0]),
    .B   (sb[0]),
    .CI  (carry),
    .SUM (fa_sum),
    .CO  (fa_co)
  );

  // State register plus registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

  // Next-state decode; the unused encoding falls back to IDLE
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = start ? RUN : IDLE;
      RUN:     state_next = last_bit ? DONE : RUN;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, bit-serial shifting and result latch
  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      ps    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      sa    <= a;
      sb    <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      ps    <= {fa_sum, ps[WIDTH-1:1]};
      carry <= fa_co;
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      cnt   <= cnt + 1'b1;
      if (last_bit) begin
        sum  <= {fa_sum, ps[WIDTH-1:1]};
        cout <= fa_co;
      end
    end
  end

endmodule
